fir_filter_param: RTL and testbench

Parametrised, streaming direct-form FIR filter with valid-qualified input and output, a handshaked, double-buffered coefficient load port, and a fixed-latency bypass mode. It sits in the sample datapath between the input sample source and downstream consumers. It generalises the fixed 16-tap, 32-bit FIR core to arbitrary data, coefficient and output widths and tap counts. It adds glitch-free coefficient swaps and rounding/saturation.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_filter_param_if.sv | 32 +++
 rtl/fir_coef_bank.sv | 86 ++++++++
 rtl/fir_filter_param.sv | 162 ++++++++++++++++
 tb/tb_fir_filter_param.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the parametrised FIR filter and its coefficient bank.
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } load_state_e;

    localparam int LATENCY = 3;

    // Full-precision accumulator width: one product plus growth for summing ntaps of them.
    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample stream, coefficient load port and output stream of fir_filter_param.
interface fir_filter_param_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 16,
    parameter int OUT_W  = 40
);
    localparam int IDX_W = $clog2(NTAPS);

    logic                     en_FIR;
    logic                     tap_valid;
    logic                     tap_ready;
    logic [IDX_W-1:0]         tap_index;
    logic signed [COEF_W-1:0] tap_value;
    logic                     tap_last;
    logic                     i_valid;
    logic signed [DATA_W-1:0] i_data;
    logic                     o_valid;
    logic signed [OUT_W-1:0]  o_data;
    logic                     o_sat;

    modport master (
        output en_FIR, tap_valid, tap_index, tap_value, tap_last, i_valid, i_data,
        input  tap_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  en_FIR, tap_valid, tap_index, tap_value, tap_last, i_valid, i_data,
        output tap_ready, o_valid, o_data, o_sat
    );

endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in shadow[], a commit copies all of it to active[].
//
// state    | meaning
// S_IDLE   | ready, no partial set in progress
// S_LOAD   | ready, partial set being written to shadow
// S_COMMIT | not ready, active <= shadow on this edge
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int NTAPS  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                         CLK,
    input  logic                         areset_n,
    input  logic                         tap_valid,
    output logic                         tap_ready,
    input  logic [IDX_W-1:0]             tap_index,
    input  logic [COEF_W-1:0]            tap_value,
    input  logic                         tap_last,
    output logic [NTAPS-1:0][COEF_W-1:0] coef
);
    load_state_e                  state_q;
    logic                         tap_ready_q;
    logic                         wr_acc;
    logic                         idx_ok;
    logic [NTAPS-1:0][COEF_W-1:0] shadow_q, shadow_d;
    logic [NTAPS-1:0][COEF_W-1:0] active_q, active_d;

    assign wr_acc    = tap_valid & tap_ready_q;
    assign idx_ok    = 32'(tap_index) < NTAPS;
    assign tap_ready = tap_ready_q;
    assign coef      = active_q;

    always_ff @(posedge CLK) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            tap_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    tap_ready_q <= 1'b1;
                    if (wr_acc) begin
                        if (tap_last) begin
                            state_q     <= S_COMMIT;
                            tap_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q     <= S_IDLE;
                    tap_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    tap_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range indices complete the handshake but never touch storage.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_acc && idx_ok) begin
            shadow_d[tap_index] = tap_value;
        end
        if (state_q == S_COMMIT) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!areset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Streaming direct-form FIR: delay line, registered products, summation, round and reduce to OUT_W.
// Build option FIR_SAT_EN: clamp out-of-range results and flag them on o_sat; otherwise wrap.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 16,
    parameter int OUT_W  = 40,
    parameter int SHIFT  = 0
) (
    input logic               CLK,
    input logic               areset_n,
    fir_filter_param_if.slave bus
);
    localparam int IDX_W  = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
    // One spare bit above the larger of accumulator+round and output keeps the round add and clamp compare exact.
    localparam int EXT_W  = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
    localparam logic signed [EXT_W-1:0] RND_ONE =
        (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`ifdef FIR_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic [NTAPS-1:0][COEF_W-1:0] coef;

    logic signed [DATA_W-1:0] d_q [NTAPS];
    logic signed [DATA_W-1:0] d_d [NTAPS];
    logic                     vld0_q, vld0_d;
    logic                     byp0_q, byp0_d;

    logic signed [PROD_W-1:0] p_q [NTAPS];
    logic signed [PROD_W-1:0] p_d [NTAPS];
    logic                     vld1_q, vld1_d;
    logic                     byp1_q, byp1_d;
    logic signed [DATA_W-1:0] bdat1_q, bdat1_d;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     vld2_q, vld2_d;
    logic                     byp2_q, byp2_d;
    logic signed [DATA_W-1:0] bdat2_q, bdat2_d;

    logic signed [EXT_W-1:0]  acc_ext;
    logic signed [EXT_W-1:0]  shifted;

    logic                     o_valid_q, o_valid_d;
    logic signed [OUT_W-1:0]  o_data_q, o_data_d;
    logic                     o_sat_q, o_sat_d;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .IDX_W  (IDX_W)
    ) u_coef_bank (
        .CLK       (CLK),
        .areset_n  (areset_n),
        .tap_valid (bus.tap_valid),
        .tap_ready (bus.tap_ready),
        .tap_index (bus.tap_index),
        .tap_value (bus.tap_value),
        .tap_last  (bus.tap_last),
        .coef      (coef)
    );

    always_comb begin
        d_d    = d_q;
        vld0_d = bus.i_valid;
        byp0_d = byp0_q;
        if (bus.i_valid) begin
            d_d[0] = bus.i_data;
            for (int k = 1; k < NTAPS; k++) begin
                d_d[k] = d_q[k-1];
            end
            byp0_d = ~bus.en_FIR;
        end

        // Products see the active bank as of this edge, so a commit never splits one sample's taps.
        for (int k = 0; k < NTAPS; k++) begin
            p_d[k] = PROD_W'(d_q[k]) * PROD_W'($signed(coef[k]));
        end
        vld1_d  = vld0_q;
        byp1_d  = byp0_q;
        bdat1_d = d_q[0];

        acc_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc_d = acc_d + ACC_W'(p_q[k]);
        end
        vld2_d  = vld1_q;
        byp2_d  = byp1_q;
        bdat2_d = bdat1_q;
    end

    always_comb begin
        acc_ext   = EXT_W'(acc_q);
        shifted   = (acc_ext + RND_ONE) >>> SHIFT;
        o_valid_d = vld2_q;
        o_data_d  = o_data_q;
        o_sat_d   = 1'b0;
        if (vld2_q) begin
            if (byp2_q) begin
                o_data_d = OUT_W'(bdat2_q);
            end else begin
`ifdef FIR_SAT_EN
                if (shifted > SAT_MAX) begin
                    o_data_d = SAT_MAX[OUT_W-1:0];
                    o_sat_d  = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    o_data_d = SAT_MIN[OUT_W-1:0];
                    o_sat_d  = 1'b1;
                end else begin
                    o_data_d = shifted[OUT_W-1:0];
                end
`else
                o_data_d = shifted[OUT_W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!areset_n) begin
            d_q       <= '{default: '0};
            vld0_q    <= 1'b0;
            byp0_q    <= 1'b0;
            p_q       <= '{default: '0};
            vld1_q    <= 1'b0;
            byp1_q    <= 1'b0;
            bdat1_q   <= '0;
            acc_q     <= '0;
            vld2_q    <= 1'b0;
            byp2_q    <= 1'b0;
            bdat2_q   <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            d_q       <= d_d;
            vld0_q    <= vld0_d;
            byp0_q    <= byp0_d;
            p_q       <= p_d;
            vld1_q    <= vld1_d;
            byp1_q    <= byp1_d;
            bdat1_q   <= bdat1_d;
            acc_q     <= acc_d;
            vld2_q    <= vld2_d;
            byp2_q    <= byp2_d;
            bdat2_q   <= bdat2_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sat_q   <= o_sat_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = o_sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench: a wide full-precision instance and a SHIFT=4/OUT_W=8 instance share one stimulus stream.
module tb_fir_filter_param;
    import fir_pkg::*;

    localparam int NT = 16;

    logic CLK = 1'b0;
    logic areset_n;
    always #5 CLK = ~CLK;

    fir_filter_param_if #(.OUT_W(40)) bus_a ();
    fir_filter_param_if #(.OUT_W(8))  bus_b ();

    fir_filter_param #(.OUT_W(40), .SHIFT(0)) dut_a (.CLK(CLK), .areset_n(areset_n), .bus(bus_a));
    fir_filter_param #(.OUT_W(8),  .SHIFT(4)) dut_b (.CLK(CLK), .areset_n(areset_n), .bus(bus_b));

    logic               rst_n_s, v_s, en_s, tv_s, tl_s;
    logic signed [15:0] x_s, tval_s;
    logic [3:0]         ti_s;
    bit                 ramp_on;
    int                 ramp_v;

    longint d_m [NT];
    longint sh_m [NT];
    longint ac_m [NT];
    int     st_m;
    bit     rdy_m;
    bit     seen_out;

    typedef struct {
        int     due;
        longint va;
        logic   sa;
        longint vb;
        logic   sb;
    } exp_t;
    exp_t sb_q[$];

    int cyc_n, n_checks, n_err;
    int coef_set [NT];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
        end
    endtask

    function automatic longint wrap_to(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic void reduce(input longint acc, input int sh, input int ow,
                                   output longint val, output logic sat);
        longint s, mx, mn;
        if (sh > 0) s = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
        else        s = acc;
        mx  = (64'sd1 <<< (ow - 1)) - 1;
        mn  = -mx - 1;
        sat = 1'b0;
`ifdef FIR_SAT_EN
        if (s > mx) begin
            val = mx;
            sat = 1'b1;
        end else if (s < mn) begin
            val = mn;
            sat = 1'b1;
        end else begin
            val = s;
        end
`else
        val = wrap_to(s, ow);
`endif
    endfunction

    task automatic drive_bus();
        areset_n        = rst_n_s;
        bus_a.en_FIR    = en_s;   bus_b.en_FIR    = en_s;
        bus_a.i_valid   = v_s;    bus_b.i_valid   = v_s;
        bus_a.i_data    = x_s;    bus_b.i_data    = x_s;
        bus_a.tap_valid = tv_s;   bus_b.tap_valid = tv_s;
        bus_a.tap_index = ti_s;   bus_b.tap_index = ti_s;
        bus_a.tap_value = tval_s; bus_b.tap_value = tval_s;
        bus_a.tap_last  = tl_s;   bus_b.tap_last  = tl_s;
    endtask

    // Reference behaviour at one rising edge.
    task automatic model_edge();
        exp_t   e;
        longint acc;
        bit     accepted;
        if (!rst_n_s) begin
            for (int k = 0; k < NT; k++) begin
                d_m[k] = 0; sh_m[k] = 0; ac_m[k] = 0;
            end
            st_m  = 0;
            rdy_m = 1'b0;
            sb_q.delete();
        end else begin
            accepted = tv_s && rdy_m;
            if (st_m == 2) begin
                for (int k = 0; k < NT; k++) ac_m[k] = sh_m[k];
                st_m  = 0;
                rdy_m = 1'b1;
            end else begin
                if (accepted && int'(ti_s) < NT) sh_m[ti_s] = longint'(tval_s);
                if (accepted && tl_s) begin
                    st_m  = 2;
                    rdy_m = 1'b0;
                end else begin
                    if (accepted) st_m = 1;
                    rdy_m = 1'b1;
                end
            end
            if (v_s) begin
                for (int k = NT - 1; k > 0; k--) d_m[k] = d_m[k-1];
                d_m[0] = longint'(x_s);
                acc = 0;
                for (int k = 0; k < NT; k++) acc += d_m[k] * ac_m[k];
                if (!en_s) begin
                    e.va = longint'(x_s);
                    e.sa = 1'b0;
                    e.vb = wrap_to(longint'(x_s), 8);
                    e.sb = 1'b0;
                end else begin
                    reduce(acc, 0, 40, e.va, e.sa);
                    reduce(acc, 4, 8, e.vb, e.sb);
                end
                e.due = cyc_n + LATENCY;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (!rst_n_s) begin
            check("rst_o_valid_a", bus_a.o_valid, 0);
            check("rst_o_data_a", bus_a.o_data, 0);
            check("rst_o_sat_b", bus_b.o_sat, 0);
            check("rst_tap_ready", bus_a.tap_ready, 0);
            seen_out = 1'b0;
        end else begin
            check("tap_ready_a", bus_a.tap_ready, rdy_m);
            check("tap_ready_b", bus_b.tap_ready, rdy_m);
            if (sb_q.size() != 0 && sb_q[0].due == cyc_n) begin
                e = sb_q.pop_front();
                check("o_valid_a", bus_a.o_valid, 1);
                check("o_data_a", bus_a.o_data, e.va);
                check("o_sat_a", bus_a.o_sat, e.sa);
                check("o_valid_b", bus_b.o_valid, 1);
                check("o_data_b", bus_b.o_data, e.vb);
                check("o_sat_b", bus_b.o_sat, e.sb);
                seen_out = 1'b1;
            end else begin
                check("idle_o_valid_a", bus_a.o_valid, 0);
                check("idle_o_valid_b", bus_b.o_valid, 0);
                if (!seen_out) begin
                    check("quiet_o_data_a", bus_a.o_data, 0);
                    check("quiet_o_data_b", bus_b.o_data, 0);
                end
            end
        end
    endtask

    task automatic cyc();
        if (ramp_on) begin
            v_s    = 1'b1;
            x_s    = 16'(ramp_v);
            ramp_v = ramp_v + 37;
        end
        drive_bus();
        @(posedge CLK);
        cyc_n++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic write_one(input int idx, input int val, input bit last);
        int guard;
        bit acc;
        guard  = 0;
        acc    = 1'b0;
        tv_s   = 1'b1;
        ti_s   = 4'(idx);
        tval_s = 16'(val);
        tl_s   = last;
        while (!acc) begin
            acc = rdy_m;
            cyc();
            guard++;
            if (!acc && guard > 8) begin
                check("tap_accept_timeout", guard, 0);
                break;
            end
        end
        tv_s = 1'b0;
        tl_s = 1'b0;
    endtask

    task automatic load_set();
        for (int k = 0; k < NT; k++) write_one(k, coef_set[k], k == NT - 1);
        repeat (2) cyc();
    endtask

    task automatic impulse(input int len);
        en_s = 1'b1;
        v_s  = 1'b1;
        x_s  = 16'sd1;
        cyc();
        x_s = 16'sd0;
        repeat (len) cyc();
        v_s = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_err = 0; cyc_n = 0; seen_out = 1'b0;
        rst_n_s = 1'b0; v_s = 1'b0; en_s = 1'b1; tv_s = 1'b0; tl_s = 1'b0;
        x_s = '0; tval_s = '0; ti_s = '0; ramp_on = 1'b0; ramp_v = -500;
        st_m = 0; rdy_m = 1'b0;

        repeat (3) cyc();
        rst_n_s = 1'b1;
        repeat (2) cyc();

        // Impulse through taps 1..16.
        for (int k = 0; k < NT; k++) coef_set[k] = k + 1;
        load_set();
        impulse(20);

        // DC 100 on every other cycle with unit taps.
        for (int k = 0; k < NT; k++) coef_set[k] = 1;
        load_set();
        for (int i = 0; i < 44; i++) begin
            v_s = (i % 2 == 0);
            x_s = 16'sd100;
            cyc();
        end
        v_s = 1'b0;
        repeat (4) cyc();

        // Reload while a ramp streams.
        for (int k = 0; k < NT; k++) coef_set[k] = 7 * k - 50;
        ramp_on = 1'b1;
        repeat (10) cyc();
        load_set();
        repeat (20) cyc();
        ramp_on = 1'b0;
        v_s = 1'b0;
        repeat (4) cyc();

        // A one-write set only replaces slot 3.
        write_one(3, 1000, 1'b1);
        repeat (2) cyc();
        impulse(18);

        // Bypass, then per-sample en_FIR toggling.
        en_s = 1'b0; v_s = 1'b1; x_s = -16'sd5;
        repeat (3) cyc();
        for (int i = 0; i < 30; i++) begin
            en_s = 1'($urandom_range(0, 1));
            v_s  = ($urandom_range(0, 3) != 0);
            x_s  = 16'($urandom);
            cyc();
        end
        v_s = 1'b0; en_s = 1'b1;
        repeat (4) cyc();

        // Full-scale positive and negative input against full-scale taps.
        for (int k = 0; k < NT; k++) coef_set[k] = 32767;
        load_set();
        v_s = 1'b1; x_s = 16'sd32767;
        repeat (20) cyc();
        x_s = -16'sd32768;
        repeat (20) cyc();
        v_s = 1'b0;
        repeat (4) cyc();

        // Small values with random taps exercise rounding.
        for (int k = 0; k < NT; k++) coef_set[k] = int'($urandom_range(0, 2000)) - 1000;
        load_set();
        for (int i = 0; i < 40; i++) begin
            v_s  = ($urandom_range(0, 4) != 0);
            en_s = ($urandom_range(0, 5) != 0);
            x_s  = 16'(int'($urandom_range(0, 40)) - 20);
            cyc();
        end
        v_s = 1'b0; en_s = 1'b1;
        repeat (4) cyc();

        // Reset in the middle of a partial load and an active stream.
        ramp_on = 1'b1;
        for (int k = 0; k < 5; k++) write_one(k, 77 + k, 1'b0);
        rst_n_s = 1'b0;
        repeat (2) cyc();
        ramp_on = 1'b0;
        v_s = 1'b0;
        rst_n_s = 1'b1;
        repeat (4) cyc();
        impulse(18);
        write_one(0, 9, 1'b1);
        repeat (2) cyc();
        impulse(18);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
